branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth; power of two, 2..256.
REQ-003 SHALL have parameter CTR_W, default 2, saturating-counter width; 1..4.
REQ-004 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port lookup_valid  input  1  fetch lookup qualifier.
REQ-007 SHALL have port lookup_pc  input  XLEN  fetch address.
REQ-008 SHALL have port pred_taken  output  1  predicted taken.
REQ-009 SHALL have port pred_target  output  XLEN  predicted next fetch address.
REQ-010 SHALL have port upd_valid  input  1  resolved-branch update strobe from execute.
REQ-011 SHALL have port upd_pc  input  XLEN  address of resolved branch.
REQ-012 SHALL have port upd_taken  input  1  actual outcome.
REQ-013 SHALL have port upd_target  input  XLEN  actual taken target.
REQ-014 SHALL have port upd_mispredict  input  1  execute flagged a misprediction.

Function
REQ-015 SHALL index with pc[IDX+1:2], IDX=log2(ENTRIES); tag = pc[XLEN-1:IDX+2].
REQ-016 SHALL keep per entry: valid, tag, target (XLEN), counter (CTR_W).
REQ-017 SHALL be lookup-combinational, zero latency: hit = lookup_valid & valid & tag match.
REQ-018 SHALL drive pred_taken = hit & counter MSB; pred_target = pred_taken ? target : lookup_pc+4 (mod 2^XLEN).
REQ-019 SHALL, when lookup_valid=0, drive pred_taken=0 and pred_target=lookup_pc+4.
REQ-020 SHALL, on upd_valid with tag hit, increment counter if upd_taken else decrement, saturating at 2^CTR_W-1 and 0; target overwritten only when upd_taken.
REQ-021 SHALL, on upd_valid tag miss with upd_taken=1, allocate: valid=1, new tag, target=upd_target, counter=2^(CTR_W-1) (weakly taken), replacing any prior occupant.
REQ-022 SHALL, on upd_valid tag miss with upd_taken=0, leave the table unchanged.
REQ-023 SHALL, on same-cycle lookup and update of one index, return pre-update contents to the lookup; new contents visible next cycle.
REQ-024 SHALL ignore upd_target and upd_mispredict when upd_valid=0.
REQ-025 SHALL treat pc+4 wrap-around from all-ones to 0x3 as plain modular addition.

Reset
REQ-026 SHALL, on reset assertion and without waiting for clk, clear all valid bits and set all counters to 2^(CTR_W-1)-1 (weakly not taken).
REQ-027 SHALL, during reset, force pred_taken=0 and drop any update presented in that cycle.
REQ-028 SHALL, after reset deasserts mid-stream, accept updates from the first following clk edge.

Configuration
REQ-029 SHALL, with macro BP_STATS_EN defined, add outputs stat_lookups and stat_mispred (32 bits each, reset 0): increment on lookup_valid and on upd_valid&upd_mispredict respectively, saturate at 0xFFFFFFFF.
REQ-030 SHALL, without BP_STATS_EN, omit both ports and counters; prediction behaviour is identical either way.

Structure
REQ-031 SHALL place CTR_W-derived constants (weak-taken, weak-not-taken, max) and index/tag width functions in shared package bp_pkg.
REQ-032 SHALL implement saturating counter update as sub-module bp_sat_ctr (inputs: value, inc; output: next value).

Verification
REQ-033 SHALL test: reset, then lookup_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-034 SHALL test: update pc=0x100 taken target=0x40 -> next-cycle lookup 0x100 gives pred_taken=1, target=0x40 (counter=2).
REQ-035 SHALL test: three not-taken updates at 0x100 -> counter 2->1->0->0, pred_taken=0 after first.
REQ-036 SHALL test: taken at 0x100 then taken at 0x140 (ENTRIES=16, same index) -> 0x100 misses, 0x140 hits target=upd_target.
REQ-037 SHALL test: same-cycle lookup/update of 0x100 -> lookup shows old value, following cycle shows new.
REQ-038 SHALL test: reset asserted mid-cycle between edges -> pred_taken falls immediately; with BP_STATS_EN, stats read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and width helpers for the branch predictor.
// Counter encodings derive from CTR_W; widths from XLEN and ENTRIES.
package bp_pkg;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - idx_w(entries) - 2;
  endfunction

  function automatic int ctr_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int ctr_wt(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int ctr_wnt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter next-state logic.
// Counts up on i_inc, down otherwise, clamping at max and zero.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_value,
  input  logic             i_inc,
  output logic [CTR_W-1:0] o_next
);

  localparam logic [CTR_W-1:0] L_MAX = CTR_W'(ctr_max(CTR_W));

  // Step toward the requested direction unless already at the rail
  always_comb begin
    o_next = i_value;
    if (i_inc) begin
      if (i_value != L_MAX) o_next = i_value + CTR_W'(1);
    end else begin
      if (i_value != '0) o_next = i_value - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Define BP_STATS_EN to add stat_lookups / stat_mispred counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int IDX   = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(XLEN, ENTRIES);

  localparam logic [CTR_W-1:0] L_WT  = CTR_W'(ctr_wt(CTR_W));
  localparam logic [CTR_W-1:0] L_WNT = CTR_W'(ctr_wnt(CTR_W));

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0] r_ctr    [ENTRIES];

  logic [IDX-1:0]   w_lidx;
  logic [TAG_W-1:0] w_ltag;
  logic             w_lhit;
  logic [IDX-1:0]   w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;
  logic             w_bump;
  logic             w_alloc;
  logic [CTR_W-1:0] w_ctr_next;
  logic             w_unused;

  assign w_lidx = lookup_pc[IDX+1:2];
  assign w_ltag = lookup_pc[XLEN-1:IDX+2];
  assign w_uidx = upd_pc[IDX+1:2];
  assign w_utag = upd_pc[XLEN-1:IDX+2];

  assign w_lhit = lookup_valid & r_valid[w_lidx]
                & (r_tag[w_lidx] == w_ltag);

  assign pred_taken  = ~reset & w_lhit & r_ctr[w_lidx][CTR_W-1];
  assign pred_target = pred_taken ? r_target[w_lidx]
                                  : lookup_pc + XLEN'(4);

  assign w_uhit  = r_valid[w_uidx] & (r_tag[w_uidx] == w_utag);
  assign w_bump  = upd_valid & w_uhit;
  assign w_alloc = upd_valid & ~w_uhit & upd_taken;

  // Low pc bits never select an entry; mispredict only feeds stats
  assign w_unused = ^{upd_mispredict, lookup_pc[1:0], upd_pc[1:0]};

  bp_sat_ctr #(
    .CTR_W(CTR_W)
  ) u_ctr (
    .i_value(r_ctr[w_uidx]),
    .i_inc  (upd_taken),
    .o_next (w_ctr_next)
  );

  // Table write: train on a tag hit, allocate on a taken miss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= L_WNT;
      end
    end else if (w_bump) begin
      r_ctr[w_uidx] <= w_ctr_next;
      if (upd_taken) r_target[w_uidx] <= upd_target;
    end else if (w_alloc) begin
      r_valid[w_uidx]  <= 1'b1;
      r_tag[w_uidx]    <= w_utag;
      r_target[w_uidx] <= upd_target;
      r_ctr[w_uidx]    <= L_WT;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_mispred;

  // Saturating event counters for lookups and mispredictions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_lookups <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (lookup_valid && r_stat_lookups != '1)
        r_stat_lookups <= r_stat_lookups + 32'd1;
      if (upd_valid && upd_mispredict && r_stat_mispred != '1)
        r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_lookups = r_stat_lookups;
  assign stat_mispred = r_stat_mispred;
`endif

endmodule
